// File: rtl/ifetch_buffer.sv
// ifetch_buffer: instruction fetch stage feeding the CPU's Iin.
// Tracks the CPU PC, fetches 16-bit words from a multi-cycle ROM over a
// req/ack handshake and holds them in a small FIFO of {addr, data} entries.
// Optional feature macro: IFB_PREFETCH_EN (defined -> two-entry FIFO with
// sequential prefetch; undefined -> single entry, fetch only on demand).
module ifetch_buffer #(
  parameter int ADDR_STEP = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  PC,
  input  logic        ADV,
  output logic [15:0] INST,
  output logic        VALID,
  output logic        MEM_REQ,
  output logic [7:0]  MEM_ADDR,
  input  logic        MEM_ACK,
  input  logic [15:0] MEM_RDATA
);

`ifdef IFB_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  // Address increment truncated to the 8-bit address space (wraps mod 256).
  localparam logic [7:0] STEP = 8'(ADDR_STEP);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  addr_reg [DEPTH];
  logic [15:0] data_reg [DEPTH];
  logic [7:0]  shift_addr [DEPTH];
  logic [15:0] shift_data [DEPTH];
  logic [1:0]  count_reg;
  logic [1:0]  count_after_pop;
  logic        head_valid, hit, flush, pop, push, issue;
  logic [7:0]  tail_addr, issue_addr;
  logic        mem_req_reg;
  logic [7:0]  mem_addr_reg;

  // Head entry decides hit/miss against the PC the CPU wants right now.
  assign head_valid = (count_reg != 2'd0);
  assign hit        = head_valid && (addr_reg[0] == PC);
  assign flush      = head_valid && !hit;
  assign pop        = ADV && hit;

  // Occupancy once this edge's pop or flush has been applied.
  assign count_after_pop = flush ? 2'd0 : (count_reg - {1'b0, pop});

  assign VALID    = hit;
  assign INST     = hit ? data_reg[0] : 16'h0000;
  assign MEM_REQ  = mem_req_reg;
  assign MEM_ADDR = mem_addr_reg;

  // Select the youngest buffered entry's address for sequential prefetch.
  always_comb begin
    tail_addr = addr_reg[0];
    for (int i = 0; i < DEPTH; i++) begin
      if (count_reg == 2'(i + 1)) tail_addr = addr_reg[i];
    end
  end

  // Empty after pop/flush -> fetch the PC itself, otherwise continue the run.
  assign issue_addr = (count_after_pop == 2'd0) ? PC : (tail_addr + STEP);

  // Fetch FSM state register.
  always_ff @(posedge CLK) begin
    if (RESET) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state, request issue and push decision.
  always_comb begin
    state_next = state_reg;
    issue      = 1'b0;
    push       = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (count_after_pop < 2'(DEPTH)) begin
          issue      = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_FETCH: begin
        if (MEM_ACK) begin
          // With entries left the outstanding word is always the next
          // sequential one; with none left it must match the current PC.
          push       = !flush && ((count_after_pop != 2'd0) || (mem_addr_reg == PC));
          state_next = S_IDLE;
        end else if (flush) begin
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (MEM_ACK) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Registered ROM request; address only changes when a new request starts.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      mem_req_reg  <= 1'b0;
      mem_addr_reg <= 8'h00;
    end else begin
      mem_req_reg <= (state_next != S_IDLE);
      if (issue) mem_addr_reg <= issue_addr;
    end
  end

  // FIFO occupancy tracks the net effect of pop/flush and push.
  always_ff @(posedge CLK) begin
    if (RESET) count_reg <= 2'd0;
    else       count_reg <= count_after_pop + {1'b0, push};
  end

  // Per-entry storage: entry 0 is the head, pops shift the queue forward.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    if (gi + 1 < DEPTH) begin : g_src
      assign shift_addr[gi] = addr_reg[gi + 1];
      assign shift_data[gi] = data_reg[gi + 1];
    end else begin : g_last
      assign shift_addr[gi] = addr_reg[gi];
      assign shift_data[gi] = data_reg[gi];
    end

    // Write the incoming word at the first free slot, else shift on pop.
    always_ff @(posedge CLK) begin
      if (push && (count_after_pop == 2'(gi))) begin
        addr_reg[gi] <= mem_addr_reg;
        data_reg[gi] <= MEM_RDATA;
      end else if (pop) begin
        addr_reg[gi] <= shift_addr[gi];
        data_reg[gi] <= shift_data[gi];
      end
    end
  end

endmodule
